limb_serial_add_sub: RTL

- Parametrised, multi-cycle successor to the fixed 8-bit add-with-carry-in / subtract datapath.
- Computes a = z + x + CIN or a = z - x - CIN over WIDTH bits, one LIMB-bit slice per clock, LSB slice first, through a single LIMB-bit adder and a registered carry.
- Valid/ready on both sides. Sits in arithmetic pipelines where area matters more than throughput, and chains for multi-word arithmetic via CIN/COUT.

---
 rtl/limb_serial_add_sub.sv | 128 ++++++++++++
 1 files changed

// File: rtl/limb_serial_add_sub.sv
// Limb-serial add/subtract. One LIMB-bit slice is processed per clock, LSB first, through a
// single adder and a carry register. Valid/ready handshakes on both the request and result sides.
module limb_serial_add_sub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LIMB  = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] x,
  input  logic             CIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic             COUT,
  output logic             OVF
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned CntW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NLIMB - 1);

  if ((LIMB == 0) || (WIDTH % LIMB != 0)) begin : g_bad_limb
    $error("limb_serial_add_sub: WIDTH must be a non-zero multiple of LIMB");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  z_q, z_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  int unsigned       base;
  logic [LIMB-1:0]   z_limb, x_limb;
  logic [LIMB:0]     sum;
  logic [WIDTH-1:0]  res;

  always_comb begin
    base   = 32'(cnt_q) * LIMB;
    z_limb = z_q[base +: LIMB];
    x_limb = x_q[base +: LIMB];
    sum    = {1'b0, z_limb} + {1'b0, x_limb} + {{LIMB{1'b0}}, carry_q};
    res    = acc_q;
    res[base +: LIMB] = sum[LIMB-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    z_d     = z_q;
    x_d     = x_q;
    acc_d   = acc_q;
    a_d     = a_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is folded into the operand: z + ~x + !CIN.
          state_d = StRun;
          cnt_d   = '0;
          carry_d = CIN ^ op;
          z_d     = z;
          x_d     = op ? ~x : x;
          acc_d   = '0;
        end
      end
      StRun: begin
        acc_d   = res;
        carry_d = sum[LIMB];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
          a_d     = res;
          cout_d  = sum[LIMB];
          // x_q already holds the effective (possibly inverted) operand, so one rule covers both ops.
          ovf_d   = (z_q[WIDTH-1] == x_q[WIDTH-1]) && (res[WIDTH-1] != z_q[WIDTH-1]);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      z_q     <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign a         = a_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;

endmodule
